// File: rtl/mips_mem_pkg.sv
// Shared types and default sizes for the instruction/data memory arbiter.
package mips_mem_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 8;

  // Tag recording which port, if any, owns the RAM read data arriving next cycle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    I    = 2'd1,
    D    = 2'd2
  } resp_t;

  // Port that won the most recent cycle in which both ports were requesting.
  typedef enum logic {
    WINNER_I = 1'b0,
    WINNER_D = 1'b1
  } winner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; when both request,
// the one that lost the previous contended cycle wins. Grants are purely combinational.
module rr_arb2
  import mips_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_reqI,
  input  logic i_reqD,
  output logic o_gntI,
  output logic o_gntD
);

  winner_t r_lastWinner;
  logic    w_contended;
  logic    w_pickI;

  // Choose the winner from the requests and history; grants are held off while in reset.
  always_comb begin
    w_contended = i_reqI & i_reqD;
    w_pickI     = i_reqI & (~i_reqD | (r_lastWinner == WINNER_D));
    o_gntI      = rst_n & w_pickI;
    o_gntD      = rst_n & i_reqD & ~w_pickI;
  end

  // Remember the winner only when both ports competed, so lone requests leave the order alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastWinner <= WINNER_D;
    end else if (w_contended) begin
      r_lastWinner <= w_pickI ? WINNER_I : WINNER_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-cycle-latency RAM between an instruction-fetch port
// and a data port. Tracks which port owns the next read data and steers the RAM address.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int addr_width = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [addr_width-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [data_width-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [addr_width-1:0] d_addr,
  input  logic [data_width-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [data_width-1:0] d_rdata,
  output logic [addr_width-1:0] ram_read_address,
  output logic [addr_width-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  logic  w_iGnt;
  logic  w_dGnt;
  resp_t r_resp;
  resp_t w_respNext;

  rr_arb2 u_rrArb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_reqI (i_req),
    .i_reqD (d_req),
    .o_gntI (w_iGnt),
    .o_gntD (w_dGnt)
  );

  // Steer the winning address to the RAM; only a granted data write may store.
  always_comb begin
    i_gnt             = w_iGnt;
    d_gnt             = w_dGnt;
    ram_read_address  = w_dGnt ? d_addr : i_addr;
    ram_write_address = w_dGnt ? d_addr : i_addr;
    ram_write         = w_dGnt & d_we;
    ram_din           = d_wdata;
  end

  // Decide who owns next cycle's RAM output; writes return nothing.
  always_comb begin
    w_respNext = NONE;
    if (w_iGnt) begin
      w_respNext = I;
    end else if (w_dGnt && !d_we) begin
      w_respNext = D;
    end
  end

  // Response tag register; reset discards any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp <= NONE;
    end else begin
      r_resp <= w_respNext;
    end
  end

  // Both ports see the raw RAM output, qualified by their own valid.
  always_comb begin
    i_rvalid = (r_resp == I);
    d_rvalid = (r_resp == D);
    i_rdata  = ram_dout;
    d_rdata  = ram_dout;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a RAM model, a rule-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] ram_read_address;
  logic [AW-1:0] ram_write_address;
  logic          ram_write;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int compareCount = 0;
  int failCount    = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.data_width(DW), .addr_width(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_req             (i_req),
    .i_addr            (i_addr),
    .i_gnt             (i_gnt),
    .i_rvalid          (i_rvalid),
    .i_rdata           (i_rdata),
    .d_req             (d_req),
    .d_we              (d_we),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_gnt             (d_gnt),
    .d_rvalid          (d_rvalid),
    .d_rdata           (d_rdata),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_write         (ram_write),
    .ram_din           (ram_din),
    .ram_dout          (ram_dout)
  );

  // Synchronous RAM: write on the edge, read data appears one cycle after its address.
  logic [DW-1:0] ramArray [0:255];
  always @(posedge clk) begin
    if (ram_write) ramArray[ram_write_address] <= ram_din;
    ram_dout <= ramArray[ram_read_address];
  end

  // Reference model state: who is preferred on a tie, what read is owed, expected memory.
  logic          mPreferI;
  int            mPend;
  logic [DW-1:0] mPendData;
  logic [DW-1:0] refMem [0:255];

  function automatic logic expectI(input logic iReq, input logic dReq,
                                   input logic preferI, input logic rstN);
    return rstN && iReq && (!dReq || preferI);
  endfunction

  function automatic logic expectD(input logic iReq, input logic dReq,
                                   input logic preferI, input logic rstN);
    return rstN && dReq && !expectI(iReq, dReq, preferI, rstN);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the reference model on each edge using the rules, not the DUT's outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPreferI <= 1'b1;
      mPend    <= 0;
    end else begin
      if (i_req && d_req) mPreferI <= !expectI(i_req, d_req, mPreferI, 1'b1);
      if (expectI(i_req, d_req, mPreferI, 1'b1)) begin
        mPend     <= 1;
        mPendData <= refMem[i_addr];
      end else if (expectD(i_req, d_req, mPreferI, 1'b1) && !d_we) begin
        mPend     <= 2;
        mPendData <= refMem[d_addr];
      end else begin
        mPend <= 0;
      end
      if (expectD(i_req, d_req, mPreferI, 1'b1) && d_we) refMem[d_addr] <= d_wdata;
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin
    checkOutput("model_i_gnt", 32'(i_gnt), 32'(expectI(i_req, d_req, mPreferI, rst_n)));
    checkOutput("model_d_gnt", 32'(d_gnt), 32'(expectD(i_req, d_req, mPreferI, rst_n)));
    checkOutput("model_ram_write", 32'(ram_write),
                32'(expectD(i_req, d_req, mPreferI, rst_n) && d_we));
    checkOutput("model_ram_din", ram_din, d_wdata);
    if (expectI(i_req, d_req, mPreferI, rst_n)) begin
      checkOutput("model_i_raddr", 32'(ram_read_address), 32'(i_addr));
    end
    if (expectD(i_req, d_req, mPreferI, rst_n)) begin
      checkOutput("model_d_raddr", 32'(ram_read_address), 32'(d_addr));
      checkOutput("model_d_waddr", 32'(ram_write_address), 32'(d_addr));
    end
    checkOutput("model_i_rvalid", 32'(i_rvalid), 32'(mPend == 1));
    checkOutput("model_d_rvalid", 32'(d_rvalid), 32'(mPend == 2));
    if (mPend == 1) checkOutput("model_i_rdata", i_rdata, mPendData);
    if (mPend == 2) checkOutput("model_d_rdata", d_rdata, mPendData);
  end

  // Drive one cycle of requests just after the edge, then return mid-cycle for checking.
  task automatic applyStimulus(input logic iReq, input logic [AW-1:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
    @(posedge clk);
    #1;
    i_req   = iReq;
    i_addr  = iAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_req   = 1'b1;
    i_addr  = 8'h05;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h10;
    d_wdata = 32'hFFFF0000;
    for (int a = 0; a < 256; a++) begin
      ramArray[a] <= 32'hA5000000 | 32'(a);
      refMem[a]   <= 32'hA5000000 | 32'(a);
    end
    ramArray[5] <= 32'hDEADBEEF;
    refMem[5]   <= 32'hDEADBEEF;

    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_i_gnt", 32'(i_gnt), 32'd0);
      checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
      checkOutput("rst_ram_write", 32'(ram_write), 32'd0);
      checkOutput("rst_i_rvalid", 32'(i_rvalid), 32'd0);
      checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    end
    #2;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    rst_n = 1'b1;

    $display("[TB] single instruction fetch");
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("fetch_i_gnt", 32'(i_gnt), 32'd1);
    checkOutput("fetch_raddr", 32'(ram_read_address), 32'h05);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("fetch_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("fetch_i_rdata", i_rdata, 32'hDEADBEEF);

    $display("[TB] data write then read-back");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'h12345678);
    checkOutput("wr_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("wr_ram_write", 32'(ram_write), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 32'h0);
    checkOutput("rd_ram_write", 32'(ram_write), 32'd0);
    checkOutput("wr_no_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("rd_d_gnt", 32'(d_gnt), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("rd_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("rd_d_rdata", d_rdata, 32'h12345678);

    $display("[TB] both ports contending after reset");
    pulseReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'h21, 1'b1, 1'b0, 8'h22, 32'h0);
      checkOutput($sformatf("rr%0d_i_gnt", k), 32'(i_gnt), 32'((k % 2) == 0));
      checkOutput($sformatf("rr%0d_d_gnt", k), 32'(d_gnt), 32'((k % 2) == 1));
      checkOutput($sformatf("rr%0d_i_rvalid", k), 32'(i_rvalid), 32'((k % 2) == 1));
      checkOutput($sformatf("rr%0d_d_rvalid", k), 32'(d_rvalid), 32'((k % 2) == 0 && k > 0));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("rr_last_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("rr_last_d_rdata", d_rdata, 32'hA5000022);

    $display("[TB] data-only traffic then first contention");
    pulseReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'(8'h30 + k), 32'h0);
      checkOutput($sformatf("donly%0d_d_gnt", k), 32'(d_gnt), 32'd1);
    end
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 8'h33, 32'h0);
    checkOutput("cont1_i_gnt", 32'(i_gnt), 32'd1);
    checkOutput("cont1_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("cont1_d_rdata", d_rdata, 32'hA5000032);
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 8'h33, 32'h0);
    checkOutput("cont2_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("cont2_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("cont2_i_rdata", i_rdata, 32'hA5000040);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("cont3_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("cont3_d_rdata", d_rdata, 32'hA5000033);

    $display("[TB] reset with an instruction read in flight");
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("flight_i_gnt", 32'(i_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("flight_i_rvalid", 32'(i_rvalid), 32'd0);
    checkOutput("flight_d_rvalid", 32'(d_rvalid), 32'd0);
    #2;
    i_req  = 1'b1;
    i_addr = 8'h06;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 8'h07;
    rst_n  = 1'b1;
    #1;
    checkOutput("resume_i_gnt", 32'(i_gnt), 32'd1);
    checkOutput("resume_d_gnt", 32'(d_gnt), 32'd0);
    @(negedge clk);
    checkOutput("resume_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("resume_i_rdata", i_rdata, 32'hA5000006);
    checkOutput("resume_d_gnt2", 32'(d_gnt), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("resume_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("resume_d_rdata", d_rdata, 32'hA5000007);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
